// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-style control unit: the control word is decoded from the state and the opcode class latched in DECODE.
// Define MC_SYSCALL_EN to build the SYSCALL state (12); otherwise op=00/fn=0C decodes as illegal.
module mc_control_fsm (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [5:0]  op,
  input  logic [5:0]  fn,
  input  logic        mem_ready,
  output logic [21:0] ctrl_out,
  output logic [3:0]  state,
  output logic        ill_op,
  output logic        instr_done
);

  localparam int B_JADDR    = 21;
  localparam int B_PCSRC    = 19;
  localparam int B_PCWR     = 18;
  localparam int B_INSTDATA = 17;
  localparam int B_MEMRD    = 16;
  localparam int B_MEMWR    = 15;
  localparam int B_IRWR     = 14;
  localparam int B_REGDST   = 12;
  localparam int B_REGIN    = 10;
  localparam int B_REGWR    = 9;
  localparam int B_ALUX     = 8;
  localparam int B_ALUY     = 6;
  localparam int B_ADDSUB   = 5;
  localparam int B_LOGIC    = 3;
  localparam int B_FNTYPE   = 1;
  localparam int B_BRCOND   = 0;

  localparam logic [1:0] FT_LUI   = 2'b00;
  localparam logic [1:0] FT_SLT   = 2'b01;
  localparam logic [1:0] FT_ARITH = 2'b10;
  localparam logic [1:0] FT_LOGIC = 2'b11;

  localparam logic [1:0] LF_AND = 2'b00;
  localparam logic [1:0] LF_OR  = 2'b01;
  localparam logic [1:0] LF_XOR = 2'b10;
  localparam logic [1:0] LF_NOR = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC_R  = 4'd2,
    S_EXEC_I  = 4'd3,
    S_ADDR    = 4'd4,
    S_LOAD_RD = 4'd5,
    S_LOAD_WB = 4'd6,
    S_STORE   = 4'd7,
    S_ALU_WB  = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_JR      = 4'd11
`ifdef MC_SYSCALL_EN
    , S_SYSCALL = 4'd12
`endif
  } state_t;

  state_t      state_q;
  state_t      dec_next;
  logic [1:0]  dec_ft;
  logic [1:0]  dec_lf;
  logic        dec_as;
  logic        dec_ill;

  logic [1:0]  cls_ft;
  logic [1:0]  cls_lf;
  logic        cls_as;
  logic        cls_rtype;
  logic        cls_link;
  logic        cls_store;

  logic [21:0] ctrl;
  logic        ill_c;
  logic        done_c;

  // Instruction dispatch and ALU function, from the IR fields seen in DECODE
  always_comb begin
    dec_next = S_FETCH;
    dec_ill  = 1'b0;
    dec_ft   = FT_ARITH;
    dec_lf   = LF_AND;
    dec_as   = 1'b0;
    if (op == 6'h00) begin
      case (fn)
        6'h20: dec_next = S_EXEC_R;
        6'h22: begin dec_next = S_EXEC_R; dec_as = 1'b1; end
        6'h24: begin dec_next = S_EXEC_R; dec_ft = FT_LOGIC; dec_lf = LF_AND; end
        6'h25: begin dec_next = S_EXEC_R; dec_ft = FT_LOGIC; dec_lf = LF_OR;  end
        6'h26: begin dec_next = S_EXEC_R; dec_ft = FT_LOGIC; dec_lf = LF_XOR; end
        6'h27: begin dec_next = S_EXEC_R; dec_ft = FT_LOGIC; dec_lf = LF_NOR; end
        6'h2A: begin dec_next = S_EXEC_R; dec_ft = FT_SLT;   dec_as = 1'b1;   end
        6'h08: dec_next = S_JR;
`ifdef MC_SYSCALL_EN
        6'h0C: dec_next = S_SYSCALL;
`endif
        default: dec_ill = 1'b1;
      endcase
    end else begin
      case (op)
        6'h08: dec_next = S_EXEC_I;
        6'h0A: begin dec_next = S_EXEC_I; dec_ft = FT_SLT;   dec_as = 1'b1;   end
        6'h0C: begin dec_next = S_EXEC_I; dec_ft = FT_LOGIC; dec_lf = LF_AND; end
        6'h0D: begin dec_next = S_EXEC_I; dec_ft = FT_LOGIC; dec_lf = LF_OR;  end
        6'h0E: begin dec_next = S_EXEC_I; dec_ft = FT_LOGIC; dec_lf = LF_XOR; end
        6'h0F: begin dec_next = S_EXEC_I; dec_ft = FT_LUI; end
        6'h23, 6'h2B:        dec_next = S_ADDR;
        6'h01, 6'h04, 6'h05: dec_next = S_BRANCH;
        6'h02, 6'h03:        dec_next = S_JUMP;
        default:             dec_ill  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      cls_ft    <= 2'b00;
      cls_lf    <= 2'b00;
      cls_as    <= 1'b0;
      cls_rtype <= 1'b0;
      cls_link  <= 1'b0;
      cls_store <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH:   if (mem_ready) state_q <= S_DECODE;
        S_DECODE: begin
          state_q   <= dec_next;
          cls_ft    <= dec_ft;
          cls_lf    <= dec_lf;
          cls_as    <= dec_as;
          cls_rtype <= (op == 6'h00);
          cls_link  <= (op == 6'h03);
          cls_store <= (op == 6'h2B);
        end
        S_EXEC_R, S_EXEC_I: state_q <= S_ALU_WB;
        S_ADDR:    state_q <= cls_store ? S_STORE : S_LOAD_RD;
        S_LOAD_RD: if (mem_ready) state_q <= S_LOAD_WB;
        S_STORE:   if (mem_ready) state_q <= S_FETCH;
        // Single-cycle final states and unused codes all return to FETCH
        default:   state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ctrl   = '0;
    ill_c  = 1'b0;
    done_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl[B_MEMRD]         = 1'b1;
        ctrl[B_FNTYPE +: 2]   = FT_ARITH;
        ctrl[B_PCSRC +: 2]    = 2'b11;
        ctrl[B_IRWR]          = mem_ready;
        ctrl[B_PCWR]          = mem_ready;
      end
      S_DECODE: begin
        ctrl[B_ALUY +: 2]     = 2'b11;
        ctrl[B_FNTYPE +: 2]   = FT_ARITH;
        ill_c                 = dec_ill;
      end
      S_EXEC_R, S_EXEC_I: begin
        ctrl[B_ALUX]          = 1'b1;
        ctrl[B_ALUY +: 2]     = (state_q == S_EXEC_R) ? 2'b01 : 2'b10;
        ctrl[B_ADDSUB]        = cls_as;
        ctrl[B_LOGIC +: 2]    = cls_lf;
        ctrl[B_FNTYPE +: 2]   = cls_ft;
      end
      S_ALU_WB: begin
        ctrl[B_REGWR]         = 1'b1;
        ctrl[B_REGIN +: 2]    = 2'b01;
        ctrl[B_REGDST +: 2]   = cls_rtype ? 2'b01 : 2'b00;
        done_c                = 1'b1;
      end
      S_ADDR: begin
        ctrl[B_ALUX]          = 1'b1;
        ctrl[B_ALUY +: 2]     = 2'b10;
        ctrl[B_FNTYPE +: 2]   = FT_ARITH;
      end
      S_LOAD_RD: begin
        ctrl[B_INSTDATA]      = 1'b1;
        ctrl[B_MEMRD]         = 1'b1;
      end
      S_LOAD_WB: begin
        ctrl[B_REGWR]         = 1'b1;
        done_c                = 1'b1;
      end
      S_STORE: begin
        ctrl[B_INSTDATA]      = 1'b1;
        ctrl[B_MEMWR]         = 1'b1;
        done_c                = mem_ready;
      end
      S_BRANCH: begin
        ctrl[B_ALUX]          = 1'b1;
        ctrl[B_ALUY +: 2]     = 2'b01;
        ctrl[B_ADDSUB]        = 1'b1;
        ctrl[B_FNTYPE +: 2]   = FT_ARITH;
        ctrl[B_BRCOND]        = 1'b1;
        ctrl[B_PCSRC +: 2]    = 2'b10;
        done_c                = 1'b1;
      end
      S_JUMP: begin
        ctrl[B_PCWR]          = 1'b1;
        ctrl[B_REGDST +: 2]   = cls_link ? 2'b10 : 2'b00;
        ctrl[B_REGIN +: 2]    = cls_link ? 2'b10 : 2'b00;
        ctrl[B_REGWR]         = cls_link;
        done_c                = 1'b1;
      end
      S_JR: begin
        ctrl[B_PCSRC +: 2]    = 2'b01;
        ctrl[B_PCWR]          = 1'b1;
        done_c                = 1'b1;
      end
`ifdef MC_SYSCALL_EN
      S_SYSCALL: begin
        ctrl[B_JADDR]         = 1'b1;
        ctrl[B_PCWR]          = 1'b1;
        ctrl[B_REGDST +: 2]   = 2'b10;
        ctrl[B_REGIN +: 2]    = 2'b10;
        ctrl[B_REGWR]         = 1'b1;
        done_c                = 1'b1;
      end
`endif
      default: ill_c = 1'b1;
    endcase
  end

  // Reset gates every output so no enable can leak while reset_n is low
  assign ctrl_out   = reset_n ? ctrl : 22'h000000;
  assign ill_op     = reset_n & ill_c;
  assign instr_done = reset_n & done_c;
  assign state      = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: each instruction is expanded from an opcode table into an expected per-cycle trace.
module tb_mc_control_fsm;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [5:0]  op;
  logic [5:0]  fn;
  logic        mem_ready;
  logic [21:0] ctrl_out;
  logic [3:0]  state;
  logic        ill_op;
  logic        instr_done;

  int    n_cmp = 0;
  int    n_bad = 0;
  string cur   = "init";

  mc_control_fsm dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op         (op),
    .fn         (fn),
    .mem_ready  (mem_ready),
    .ctrl_out   (ctrl_out),
    .state      (state),
    .ill_op     (ill_op),
    .instr_done (instr_done)
  );

  always #5 clk = ~clk;

  localparam int P_JADDR = 21, P_PCSRC = 19, P_PCWR = 18, P_INSTDATA = 17, P_MEMRD = 16;
  localparam int P_MEMWR = 15, P_IRWR = 14, P_REGDST = 12, P_REGIN = 10, P_REGWR = 9;
  localparam int P_ALUX = 8, P_ALUY = 6, P_AS = 5, P_LF = 3, P_FT = 1, P_BR = 0;

  typedef enum {K_R, K_I, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_SYS, K_ILL} kind_e;

  typedef struct {
    logic [5:0] op;
    int         fn;   // -1: function field ignored
    kind_e      k;
    int         ft;
    int         lf;
    int         as;
  } ins_t;

  typedef struct {
    int          st;
    logic [21:0] cw;
    logic        ill;
    logic        done;
    logic        mr;
  } step_t;

  ins_t  itab[$];
  step_t exp_q[$];

  function automatic logic [21:0] fld(input int pos, input int v);
    logic [21:0] r;
    r = 22'(v);
    return r << pos;
  endfunction

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [21:0] cw_fetch(input logic mr);
    logic [21:0] r;
    r = fld(P_MEMRD, 1) | fld(P_PCSRC, 3) | fld(P_FT, 2);
    if (mr) r = r | fld(P_IRWR, 1) | fld(P_PCWR, 1);
    return r;
  endfunction

  function void add(input logic [5:0] o, input int f, input kind_e k, input int ft, input int lf, input int as);
    ins_t e;
    e.op = o; e.fn = f; e.k = k; e.ft = ft; e.lf = lf; e.as = as;
    itab.push_back(e);
  endfunction

  function automatic int find(input logic [5:0] o, input logic [5:0] f);
    foreach (itab[i])
      if (itab[i].op == o && (itab[i].fn < 0 || itab[i].fn == int'(f))) return i;
    return -1;
  endfunction

  function void push(input int st, input logic [21:0] cw, input logic ill, input logic done, input logic mr);
    step_t s;
    s.st = st; s.cw = cw; s.ill = ill; s.done = done; s.mr = mr;
    exp_q.push_back(s);
  endfunction

  // Expected cycle-by-cycle behaviour of one instruction, from its class and wait counts
  function void build(input kind_e k, input int ft, input int lf, input int as, input int wf, input int wm);
    logic [21:0] alu;
    alu = fld(P_FT, ft) | fld(P_LF, lf) | fld(P_AS, as);
    for (int j = 0; j < wf; j++) push(0, cw_fetch(1'b0), 1'b0, 1'b0, 1'b0);
    push(0, cw_fetch(1'b1), 1'b0, 1'b0, 1'b1);
    push(1, fld(P_ALUY, 3) | fld(P_FT, 2), (k == K_ILL), 1'b0, rb());
    case (k)
      K_R: begin
        push(2, fld(P_ALUX, 1) | fld(P_ALUY, 1) | alu, 1'b0, 1'b0, rb());
        push(8, fld(P_REGWR, 1) | fld(P_REGIN, 1) | fld(P_REGDST, 1), 1'b0, 1'b1, rb());
      end
      K_I: begin
        push(3, fld(P_ALUX, 1) | fld(P_ALUY, 2) | alu, 1'b0, 1'b0, rb());
        push(8, fld(P_REGWR, 1) | fld(P_REGIN, 1), 1'b0, 1'b1, rb());
      end
      K_LW: begin
        push(4, fld(P_ALUX, 1) | fld(P_ALUY, 2) | fld(P_FT, 2), 1'b0, 1'b0, rb());
        for (int j = 0; j < wm; j++) push(5, fld(P_INSTDATA, 1) | fld(P_MEMRD, 1), 1'b0, 1'b0, 1'b0);
        push(5, fld(P_INSTDATA, 1) | fld(P_MEMRD, 1), 1'b0, 1'b0, 1'b1);
        push(6, fld(P_REGWR, 1), 1'b0, 1'b1, rb());
      end
      K_SW: begin
        push(4, fld(P_ALUX, 1) | fld(P_ALUY, 2) | fld(P_FT, 2), 1'b0, 1'b0, rb());
        for (int j = 0; j < wm; j++) push(7, fld(P_INSTDATA, 1) | fld(P_MEMWR, 1), 1'b0, 1'b0, 1'b0);
        push(7, fld(P_INSTDATA, 1) | fld(P_MEMWR, 1), 1'b0, 1'b1, 1'b1);
      end
      K_BR:  push(9, fld(P_ALUX, 1) | fld(P_ALUY, 1) | fld(P_AS, 1) | fld(P_FT, 2) | fld(P_BR, 1) | fld(P_PCSRC, 2),
                  1'b0, 1'b1, rb());
      K_J:   push(10, fld(P_PCWR, 1), 1'b0, 1'b1, rb());
      K_JAL: push(10, fld(P_PCWR, 1) | fld(P_REGDST, 2) | fld(P_REGIN, 2) | fld(P_REGWR, 1), 1'b0, 1'b1, rb());
      K_JR:  push(11, fld(P_PCSRC, 1) | fld(P_PCWR, 1), 1'b0, 1'b1, rb());
      K_SYS: push(12, fld(P_JADDR, 1) | fld(P_PCWR, 1) | fld(P_REGDST, 2) | fld(P_REGIN, 2) | fld(P_REGWR, 1),
                  1'b0, 1'b1, rb());
      default: ;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s %s: observed 0x%0h expected 0x%0h", cur, name, obs, exp);
    end
  endtask

  task automatic play(input logic [5:0] o, input logic [5:0] f);
    step_t s;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      @(negedge clk);
      if (s.st == 0) begin
        op = 6'($urandom);
        fn = 6'($urandom);
      end else begin
        op = o;
        fn = f;
      end
      mem_ready = s.mr;
      #1;
      chk("state", 32'(state), 32'(s.st));
      chk("ctrl_out", 32'(ctrl_out), 32'(s.cw));
      chk("ill_op", 32'(ill_op), 32'(s.ill));
      chk("instr_done", 32'(instr_done), 32'(s.done));
    end
  endtask

  task automatic prep(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm);
    int    i;
    kind_e k;
    i = find(o, f);
    k = K_ILL;
    if (i >= 0) k = itab[i].k;
    cur = $sformatf("op%02h/fn%02h", o, f);
    if (i >= 0) build(k, itab[i].ft, itab[i].lf, itab[i].as, wf, wm);
    else        build(k, 2, 0, 0, wf, wm);
  endtask

  task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input int wf, input int wm);
    prep(o, f, wf, wm);
    play(o, f);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    add(6'h00, 'h20, K_R, 2, 0, 0);  add(6'h00, 'h22, K_R, 2, 0, 1);
    add(6'h00, 'h24, K_R, 3, 0, 0);  add(6'h00, 'h25, K_R, 3, 1, 0);
    add(6'h00, 'h26, K_R, 3, 2, 0);  add(6'h00, 'h27, K_R, 3, 3, 0);
    add(6'h00, 'h2A, K_R, 1, 0, 1);  add(6'h00, 'h08, K_JR, 0, 0, 0);
`ifdef MC_SYSCALL_EN
    add(6'h00, 'h0C, K_SYS, 0, 0, 0);
`endif
    add(6'h08, -1, K_I, 2, 0, 0);    add(6'h0A, -1, K_I, 1, 0, 1);
    add(6'h0C, -1, K_I, 3, 0, 0);    add(6'h0D, -1, K_I, 3, 1, 0);
    add(6'h0E, -1, K_I, 3, 2, 0);    add(6'h0F, -1, K_I, 0, 0, 0);
    add(6'h23, -1, K_LW, 0, 0, 0);   add(6'h2B, -1, K_SW, 0, 0, 0);
    add(6'h01, -1, K_BR, 0, 0, 0);   add(6'h04, -1, K_BR, 0, 0, 0);
    add(6'h05, -1, K_BR, 0, 0, 0);   add(6'h02, -1, K_J, 0, 0, 0);
    add(6'h03, -1, K_JAL, 0, 0, 0);

    // Reset: outputs forced low before any clock edge, then held
    reset_n = 1'b0; mem_ready = 1'b1; op = 6'h00; fn = 6'h00;
    cur = "reset";
    #2;
    chk("state", 32'(state), 32'd0);
    chk("ctrl_out", 32'(ctrl_out), 32'd0);
    chk("ill_op", 32'(ill_op), 32'd0);
    chk("instr_done", 32'(instr_done), 32'd0);
    @(posedge clk); #2;
    chk("state_held", 32'(state), 32'd0);
    chk("ctrl_held", 32'(ctrl_out), 32'd0);
    reset_n = 1'b1;

    // Directed: add, lw with memory stalls, jal, j, jr, syscall, illegal, branch with fetch stalls
    do_instr(6'h00, 6'h20, 0, 0);
    do_instr(6'h23, 6'h15, 0, 2);
    do_instr(6'h03, 6'h00, 0, 0);
    do_instr(6'h02, 6'h3F, 0, 0);
    do_instr(6'h00, 6'h08, 0, 0);
    do_instr(6'h00, 6'h0C, 0, 0);
    do_instr(6'h3F, 6'h00, 0, 0);
    do_instr(6'h04, 6'h00, 2, 0);
    do_instr(6'h0F, 6'h00, 1, 0);
    do_instr(6'h2B, 6'h00, 0, 1);

    // Reset in the middle of a stalled store abandons the write immediately
    prep(6'h2B, 6'h00, 0, 3);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    play(6'h2B, 6'h00);
    cur = "store_reset";
    #1 reset_n = 1'b0; mem_ready = 1'b1;
    #1;
    chk("state", 32'(state), 32'd0);
    chk("ctrl_out", 32'(ctrl_out), 32'd0);
    chk("ill_op", 32'(ill_op), 32'd0);
    chk("instr_done", 32'(instr_done), 32'd0);
    @(posedge clk); #2;
    chk("state_held", 32'(state), 32'd0);
    chk("memwrite_held", 32'(ctrl_out[15]), 32'd0);
    reset_n = 1'b1;
    do_instr(6'h00, 6'h2A, 0, 0);

    // Random instruction mix, mostly legal, with random memory wait states
    for (int it = 0; it < 250; it++) begin
      logic [5:0] o;
      logic [5:0] f;
      int         idx;
      if ($urandom_range(0, 4) != 0) begin
        idx = int'($urandom_range(0, itab.size() - 1));
        o   = itab[idx].op;
        f   = (itab[idx].fn < 0) ? 6'($urandom) : 6'(itab[idx].fn);
      end else begin
        o = 6'($urandom);
        f = 6'($urandom);
      end
      do_instr(o, f, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
